// File: rtl/alpu_pipe.sv
// -----------------------------------------------------------------------------
// alpu_pipe -- pipelined arithmetic/logic processing unit
//
// All arithmetic and flag evaluation is combinational in front of slot 0.
// STAGES registered slots then form an elastic valid/ready chain that only
// delays the result. A slot loads when it is empty or when its successor
// takes its current contents in the same cycle. Each op carries an opaque tag
// (the destination register ID), so results retire in accept order.
//
// Parameters:
//   REG_WIDTH  operand/result width (>=2, power of 2)
//   STAGES     number of pipeline slots = unstalled latency (1..4)
//   TAG_WIDTH  width of the pass-through tag
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  upstream handshake
//   instr_i, a_i, b_i,       opcode, operands (b_i also gives the shift
//   cin_i, tag_i             amount), carry-in, tag
//   out_valid_o/out_ready_i  downstream handshake
//   out_o, cout_o, zero_o,   result and flags (carry, zero, negative,
//   neg_o, ovf_o, illegal_o  signed overflow, reserved opcode)
//   tag_o                    tag of the presented result
// -----------------------------------------------------------------------------
module alpu_pipe #(
    parameter int REG_WIDTH = 8,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0]           instr_i,
    input  logic [REG_WIDTH-1:0] a_i,
    input  logic [REG_WIDTH-1:0] b_i,
    input  logic                 cin_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [REG_WIDTH-1:0] out_o,
    output logic                 cout_o,
    output logic                 zero_o,
    output logic                 neg_o,
    output logic                 ovf_o,
    output logic                 illegal_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    localparam int MSB  = REG_WIDTH - 1;
    localparam int SH_W = $clog2(REG_WIDTH);
    // Slot payload: {illegal, ovf, neg, zero, carry, tag, result}
    localparam int PW   = REG_WIDTH + TAG_WIDTH + 5;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ASR  = 4'hA;
    localparam logic [3:0] OP_PASS = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;

    // ------------------------------------------------------------------
    // Compute stage (combinational)
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0] w_bop;
    logic                 w_ci;
    logic [REG_WIDTH:0]   w_sum;
    logic                 w_arith_v;
    logic [SH_W-1:0]      w_amt;
    logic [REG_WIDTH:0]   w_shl;
    logic [REG_WIDTH:0]   w_shr;
    logic [REG_WIDTH:0]   w_asr;
    logic [REG_WIDTH-1:0] w_res;
    logic                 w_c;
    logic                 w_v;
    logic                 w_ill;
    logic [REG_WIDTH-1:0] w_flag_src;
    logic                 w_zero;
    logic                 w_neg;
    logic [PW-1:0]        w_comp;

    // Subtracts are A + ~B + carry-in, so the carry out is the no-borrow flag.
    always_comb begin
        w_bop = b_i;
        w_ci  = 1'b0;
        case (instr_i)
            OP_ADC:         w_ci = cin_i;
            OP_SUB, OP_CMP: begin w_bop = ~b_i; w_ci = 1'b1;  end
            OP_SBC:         begin w_bop = ~b_i; w_ci = cin_i; end
            default:        ;
        endcase
    end

    assign w_sum     = {1'b0, a_i} + {1'b0, w_bop} + {{REG_WIDTH{1'b0}}, w_ci};
    assign w_arith_v = (a_i[MSB] == w_bop[MSB]) && (w_sum[MSB] != a_i[MSB]);

    // Shifts run one bit wider so the last bit shifted out lands in a fixed
    // position: bit REG_WIDTH for left shifts, bit 0 for right shifts. With a
    // zero amount that extra bit is the zero pad, giving carry 0.
    assign w_amt = b_i[SH_W-1:0];
    assign w_shl = {1'b0, a_i} << w_amt;
    assign w_shr = {a_i, 1'b0} >> w_amt;
    assign w_asr = $signed({a_i, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (instr_i)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[REG_WIDTH];
                w_v   = w_arith_v;
            end
            OP_AND:  w_res = a_i & b_i;
            OP_OR:   w_res = a_i | b_i;
            OP_XOR:  w_res = a_i ^ b_i;
            OP_NOT:  w_res = ~a_i;
            OP_SHL:  begin w_res = w_shl[MSB:0];       w_c = w_shl[REG_WIDTH]; end
            OP_SHR:  begin w_res = w_shr[REG_WIDTH:1]; w_c = w_shr[0];         end
            OP_ASR:  begin w_res = w_asr[REG_WIDTH:1]; w_c = w_asr[0];         end
            OP_PASS: w_res = b_i;
            OP_CMP: begin
                w_res = a_i;
                w_c   = w_sum[REG_WIDTH];
                w_v   = w_arith_v;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // CMP reports the operand but its Z/N come from the difference.
    // A reserved opcode yields out=0 with every flag except illegal clear.
    assign w_flag_src = (instr_i == OP_CMP) ? w_sum[MSB:0] : w_res;
    assign w_zero     = !w_ill && (w_flag_src == '0);
    assign w_neg      = w_flag_src[MSB];
    assign w_comp     = {w_ill, w_v, w_neg, w_zero, w_c, tag_i, w_res};

    // ------------------------------------------------------------------
    // Elastic slot chain
    // ------------------------------------------------------------------
    // Holds in_ready_o low until the first edge after reset is released.
    logic r_rdy_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdy_en <= 1'b0;
        else          r_rdy_en <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slot
            logic          r_valid;
            logic [PW-1:0] r_data;
            logic          w_adv;       // contents leave this slot this cycle
            logic          w_load;      // slot captures its source this edge
            logic          w_src_valid;
            logic [PW-1:0] w_src_data;

            if (gi == STAGES - 1) begin : g_last
                assign w_adv = r_valid && out_ready_i;
            end else begin : g_mid
                assign w_adv = r_valid && g_slot[gi+1].w_load;
            end

            if (gi == 0) begin : g_first
                assign w_src_valid = in_valid_i && r_rdy_en;
                assign w_src_data  = w_comp;
            end else begin : g_chain
                assign w_src_valid = g_slot[gi-1].r_valid;
                assign w_src_data  = g_slot[gi-1].r_data;
            end

            assign w_load = !r_valid || w_adv;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load) begin
                    r_valid <= w_src_valid;
                    // A bubble leaves the old data in place; it is masked by
                    // the cleared valid bit.
                    if (w_src_valid) r_data <= w_src_data;
                end
            end
        end
    endgenerate

    logic [PW-1:0] w_out_data;

    assign in_ready_o  = r_rdy_en && g_slot[0].w_load;
    assign out_valid_o = g_slot[STAGES-1].r_valid;
    assign w_out_data  = g_slot[STAGES-1].r_data;

    assign out_o     = w_out_data[MSB:0];
    assign tag_o     = w_out_data[REG_WIDTH +: TAG_WIDTH];
    assign cout_o    = w_out_data[REG_WIDTH + TAG_WIDTH];
    assign zero_o    = w_out_data[REG_WIDTH + TAG_WIDTH + 1];
    assign neg_o     = w_out_data[REG_WIDTH + TAG_WIDTH + 2];
    assign ovf_o     = w_out_data[REG_WIDTH + TAG_WIDTH + 3];
    assign illegal_o = w_out_data[REG_WIDTH + TAG_WIDTH + 4];

endmodule

// File: doc/alpu_pipe.md
Name: alpu_pipe

Overview:
Parametrised, pipelined arithmetic/logic processing unit. It is the next generation of the single-cycle 4-bit-opcode ALPU.
- Adds a configurable register width and pipeline depth.
- Adds valid/ready handshaking on both sides, a full flag set and a pass-through tag.
- Sits between the issue stage and writeback. The tag carries the destination register ID so results can retire in order.

Parameters:
REG_WIDTH, 8, operand/result width in bits; >=2 and a power of 2.
STAGES, 2, pipeline depth and unstalled latency in cycles; legal range 1..4.
TAG_WIDTH, 4, width of the opaque tag carried alongside each op.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid_i  input  1  upstream offers an op.
in_ready_o  output  1  block accepts an op this cycle.
instr_i  input  4  opcode.
a_i  input  REG_WIDTH  operand A.
b_i  input  REG_WIDTH  operand B, or the shift amount.
cin_i  input  1  carry-in; used by ADC/SBC only.
tag_i  input  TAG_WIDTH  tag, returned unchanged with the result.
out_valid_o  output  1  result is available.
out_ready_i  input  1  downstream accepts the result.
out_o  output  REG_WIDTH  result.
cout_o  output  1  carry flag.
zero_o  output  1  result == 0.
neg_o  output  1  result MSB.
ovf_o  output  1  signed overflow.
illegal_o  output  1  opcode was reserved.
tag_o  output  TAG_WIDTH  tag of the current result.

Behaviour:
- Reset, asynchronous on reset_n low:
  - All stage valid bits clear immediately and all registered outputs go to 0; out_valid_o=0.
  - In-flight ops are discarded, not completed.
  - in_ready_o=1 from the first edge after reset release.
- Handshake:
  - An op is accepted on a cycle where in_valid_i && in_ready_o.
  - A result is consumed on a cycle where out_valid_o && out_ready_i.
  - While out_valid_o=1 && out_ready_i=0, all output signals hold stable.
- Pipeline:
  - STAGES registered slots form an elastic chain. Slot k loads when it is empty or slot k+1 is advancing this cycle.
  - in_ready_o = !slot0_valid || slot0_advancing. This term is combinational from out_ready_i through the chain; no input-to-ready path exists other than via out_ready_i.
  - Throughput is 1 op/cycle with out_ready_i held high.
  - Latency is STAGES cycles from the accept edge to out_valid_o.
  - Results appear in accept order; no loss, no duplication.
  - Under full stall the block holds exactly STAGES ops.
  - Accept and consume in the same cycle on a full pipe is legal and keeps occupancy constant.
- Compute:
  - All arithmetic and flag evaluation happens combinationally before slot 0. Later slots only delay the data.
  - Arithmetic is REG_WIDTH+1 bits wide. Carry = bit REG_WIDTH.
  - For subtracts, cout_o is the no-borrow flag: 1 when A >= B unsigned, including the borrow-in for SBC.
  - V = (A_msb==Bop_msb) && (R_msb!=A_msb), where Bop is the inverted B for subtracts.
- Opcodes:
  - 0 ADD: A+B; C and V updated.
  - 1 ADC: A+B+cin; C and V updated.
  - 2 SUB: A-B; C and V updated.
  - 3 SBC: A-B-!cin; C and V updated.
  - 4 AND, 5 OR, 6 XOR, 7 NOT A: logic ops; C=0, V=0.
  - 8 SHL, 9 SHR (logical), A ASR:
    - Amount = b_i[log2(REG_WIDTH)-1:0]; upper bits of b_i are ignored.
    - C = last bit shifted out; amount 0 gives C=0.
    - V=0.
  - B PASS B: out = B; C=0, V=0.
  - C CMP: flags as for SUB, but out_o = A.
  - D-F reserved: out=0, all flags 0 except illegal_o=1. The op still occupies a slot and returns its tag.
- zero_o and neg_o are always derived from the final out_o (for CMP, from the subtract result).

Test Plan:
(All scenarios use REG_WIDTH=8, STAGES=2 unless stated.)
1. ADD a=0xF0, b=0x20, cin=1 -> after 2 cycles: out=0x10, C=1, V=0, Z=0, N=0; cin ignored; tag returned unchanged.
2. SUB a=0x80, b=0x01 -> out=0x7F, C=1, V=1, N=0. Then CMP a=0x05, b=0x05 -> out=0x05, Z=1, C=1.
3. SHL a=0x81, b=0x09 -> out=0x02, C=1 (amount 1). ASR a=0x80, b=0x03 -> out=0xF0, C=0.
4. STAGES=3: 6 back-to-back ops with out_ready_i=0 for 5 cycles -> in_ready_o drops after 3 accepts; all 6 results then emerge in order at 1/cycle; tags 0..5 sequential.
5. Opcode 0xE with tag 0x9 -> out=0, illegal_o=1, tag_o=0x9. The following ADD has illegal_o=0.
6. reset_n low mid-stream with 2 ops in flight -> out_valid_o=0 immediately (no clock needed). After release, no stale results appear and the next op has latency STAGES.
